// File: rtl/mc_ctrl_if.sv
// Control bus between the multi-cycle controller and the MIPS-lite datapath.
// The controller is the master: it consumes IR fields and the ALU flag and drives all controls.
interface mc_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_wr;
    logic       ir_wr;
    logic       reg_wr;
    logic       mem_wr;
    logic [1:0] npc_op;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src;
    logic [1:0] ext_op;
    logic [1:0] alu_op;
    logic [3:0] state;

    modport master (
        input  op, funct, zero,
        output pc_wr, ir_wr, reg_wr, mem_wr, npc_op, reg_dst, mem_to_reg,
               alu_src, ext_op, alu_op, state
    );

    modport slave (
        output op, funct, zero,
        input  pc_wr, ir_wr, reg_wr, mem_wr, npc_op, reg_dst, mem_to_reg,
               alu_src, ext_op, alu_op, state
    );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-lite datapath: sequences fetch, decode,
// execute, memory and write-back, driving every write enable and mux select.
module mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    mc_ctrl_if.master   bus
);
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXE      = 4'd2,
        S_ALU_WB   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WB   = 4'd6,
        S_MEM_WR   = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9
    } state_t;

    typedef enum logic [3:0] {
        I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_ILL
    } instr_t;

    typedef struct packed {
        logic       pc_wr;
        logic       ir_wr;
        logic       reg_wr;
        logic       mem_wr;
        logic [1:0] npc_op;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src;
        logic [1:0] ext_op;
        logic [1:0] alu_op;
    } ctrl_t;

    state_t cur, nxt;
    instr_t instr;
    ctrl_t  c;

    always_comb begin
        instr = I_ILL;
        case (bus.op)
            6'h00: begin
                case (bus.funct)
                    6'h21:   instr = I_ADDU;
                    6'h23:   instr = I_SUBU;
                    6'h08:   instr = I_JR;
                    default: instr = I_ILL;
                endcase
            end
            6'h0D:   instr = I_ORI;
            6'h0F:   instr = I_LUI;
            6'h23:   instr = I_LW;
            6'h2B:   instr = I_SW;
            6'h04:   instr = I_BEQ;
            6'h02:   instr = I_J;
            6'h03:   instr = I_JAL;
            default: instr = I_ILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cur <= S_FETCH;
        else      cur <= nxt;
    end

    always_comb begin
        nxt = S_FETCH;
        case (cur)
            S_FETCH:  nxt = S_DECODE;
            S_DECODE: begin
                case (instr)
                    I_ADDU, I_SUBU, I_ORI, I_LUI: nxt = S_EXE;
                    I_LW, I_SW:                   nxt = S_MEM_ADDR;
                    I_BEQ:                        nxt = S_BRANCH;
                    I_J, I_JAL, I_JR:             nxt = S_JUMP;
                    default:                      nxt = S_FETCH;
                endcase
            end
            S_EXE:      nxt = S_ALU_WB;
            S_MEM_ADDR: nxt = (instr == I_LW) ? S_MEM_RD :
                              (instr == I_SW) ? S_MEM_WR : S_FETCH;
            S_MEM_RD:   nxt = S_MEM_WB;
            default:    nxt = S_FETCH;
        endcase
    end

    always_comb begin
        c = '0;
        case (cur)
            S_FETCH: begin
                c.pc_wr = 1'b1;
                c.ir_wr = 1'b1;
            end
            S_EXE, S_ALU_WB: begin
                c.reg_wr = (cur == S_ALU_WB);
                case (instr)
                    I_ADDU: c.reg_dst = 2'b01;
                    I_SUBU: begin
                        c.alu_op  = 2'b01;
                        c.reg_dst = 2'b01;
                    end
                    I_ORI: begin
                        c.alu_op  = 2'b10;
                        c.alu_src = 1'b1;
                    end
                    I_LUI: begin
                        c.alu_op  = 2'b10;
                        c.alu_src = 1'b1;
                        c.ext_op  = 2'b10;
                    end
                    default: c.reg_wr = 1'b0;
                endcase
            end
            S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR: begin
                // Address operands stay selected so the DM address is stable all the way through.
                c.alu_src = 1'b1;
                c.ext_op  = 2'b01;
                c.mem_wr  = (cur == S_MEM_WR);
                if (cur == S_MEM_WB) begin
                    c.reg_wr     = 1'b1;
                    c.mem_to_reg = 2'b01;
                end
            end
            S_BRANCH: begin
                c.alu_op = 2'b01;
                c.ext_op = 2'b01;
                c.npc_op = 2'b01;
                c.pc_wr  = bus.zero;
            end
            S_JUMP: begin
                case (instr)
                    I_J: begin
                        c.pc_wr  = 1'b1;
                        c.npc_op = 2'b10;
                    end
                    I_JAL: begin
                        c.pc_wr      = 1'b1;
                        c.npc_op     = 2'b10;
                        c.reg_wr     = 1'b1;
                        c.reg_dst    = 2'b10;
                        c.mem_to_reg = 2'b10;
                    end
                    I_JR: begin
                        c.pc_wr  = 1'b1;
                        c.npc_op = 2'b11;
                    end
                    default: c.pc_wr = 1'b0;
                endcase
            end
            default: c = '0;
        endcase
    end

    // Write enables are gated by reset directly so a pending write dies the instant rst falls.
    assign bus.pc_wr      = c.pc_wr  & rst;
    assign bus.ir_wr      = c.ir_wr  & rst;
    assign bus.reg_wr     = c.reg_wr & rst;
    assign bus.mem_wr     = c.mem_wr & rst;
    assign bus.npc_op     = c.npc_op;
    assign bus.reg_dst    = c.reg_dst;
    assign bus.mem_to_reg = c.mem_to_reg;
    assign bus.alu_src    = c.alu_src;
    assign bus.ext_op     = c.ext_op;
    assign bus.alu_op     = c.alu_op;
    assign bus.state      = cur;
endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-instruction expected state/control traces
// built from the instruction table, directed scenarios plus a random instruction stream.
module tb_mc_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mc_ctrl_if bus();
    mc_ctrl dut (.clk(clk), .rst(rst), .bus(bus.master));

    typedef struct packed {
        logic       pc_wr;
        logic       ir_wr;
        logic       reg_wr;
        logic       mem_wr;
        logic [1:0] npc_op;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src;
        logic [1:0] ext_op;
        logic [1:0] alu_op;
    } ctrl_t;

    ctrl_t got;
    assign got = {bus.pc_wr, bus.ir_wr, bus.reg_wr, bus.mem_wr, bus.npc_op, bus.reg_dst,
                  bus.mem_to_reg, bus.alu_src, bus.ext_op, bus.alu_op};

    int    n_chk  = 0;
    int    n_pass = 0;
    int    exp_s[$];
    ctrl_t exp_w[$];

    function automatic ctrl_t fetch_word();
        ctrl_t w = '0;
        w.pc_wr = 1'b1;
        w.ir_wr = 1'b1;
        return w;
    endfunction

    task automatic push(input int s, input ctrl_t w);
        exp_s.push_back(s);
        exp_w.push_back(w);
    endtask

    // Expected (state, controls) per cycle of one instruction, from the instruction table.
    task automatic model(input logic [5:0] o, input logic [5:0] f, input logic z);
        ctrl_t w = '0;
        exp_s.delete();
        exp_w.delete();
        push(0, fetch_word());
        push(1, '0);
        if (o == 6'h00 && (f == 6'h21 || f == 6'h23)) begin
            w.reg_dst = 2'b01;
            w.alu_op  = (f == 6'h23) ? 2'b01 : 2'b00;
            push(2, w);
            w.reg_wr = 1'b1;
            push(3, w);
        end else if (o == 6'h0D || o == 6'h0F) begin
            w.alu_op  = 2'b10;
            w.alu_src = 1'b1;
            w.ext_op  = (o == 6'h0F) ? 2'b10 : 2'b00;
            push(2, w);
            w.reg_wr = 1'b1;
            push(3, w);
        end else if (o == 6'h23) begin
            w.alu_src = 1'b1;
            w.ext_op  = 2'b01;
            push(4, w);
            push(5, w);
            w.reg_wr     = 1'b1;
            w.mem_to_reg = 2'b01;
            push(6, w);
        end else if (o == 6'h2B) begin
            w.alu_src = 1'b1;
            w.ext_op  = 2'b01;
            push(4, w);
            w.mem_wr = 1'b1;
            push(7, w);
        end else if (o == 6'h04) begin
            w.alu_op = 2'b01;
            w.ext_op = 2'b01;
            w.npc_op = 2'b01;
            w.pc_wr  = z;
            push(8, w);
        end else if (o == 6'h02 || o == 6'h03) begin
            w.pc_wr  = 1'b1;
            w.npc_op = 2'b10;
            if (o == 6'h03) begin
                w.reg_wr     = 1'b1;
                w.reg_dst    = 2'b10;
                w.mem_to_reg = 2'b10;
            end
            push(9, w);
        end else if (o == 6'h00 && f == 6'h08) begin
            w.pc_wr  = 1'b1;
            w.npc_op = 2'b11;
            push(9, w);
        end
    endtask

    // Called mid-FETCH; leaves the DUT mid-FETCH of the following instruction.
    task automatic run(input logic [5:0] o, input logic [5:0] f, input logic z, input string tag);
        model(o, f, z);
        bus.op    = o;
        bus.funct = f;
        bus.zero  = z;
        #1;
        for (int k = 0; k < exp_s.size(); k++) begin
            if (k > 0) begin
                @(posedge clk);
                #2;
            end
            n_chk++;
            if (bus.state !== 4'(exp_s[k]))
                $display("FAIL %s state cyc%0d got %0d exp %0d", tag, k, bus.state, exp_s[k]);
            else n_pass++;
            n_chk++;
            if (got !== exp_w[k])
                $display("FAIL %s ctrl cyc%0d got %h exp %h", tag, k, got, exp_w[k]);
            else n_pass++;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        bus.op    = 6'h23;
        bus.funct = 6'h21;
        bus.zero  = 1'b1;
        rst = 1'b0;
        #22;
        n_chk++;
        if (bus.state !== 4'd0) $display("FAIL reset_state got %0d exp 0", bus.state);
        else n_pass++;
        n_chk++;
        if (got !== ctrl_t'('0)) $display("FAIL reset_ctrl got %h exp 0", got);
        else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_chk++;
        if (got !== fetch_word()) $display("FAIL reset_release got %h exp %h", got, fetch_word());
        else n_pass++;
    endtask

    task automatic test_alu();
        run(6'h00, 6'h21, 1'b0, "addu");
        run(6'h00, 6'h23, 1'b1, "subu");
        run(6'h0D, 6'h15, 1'b0, "ori");
        run(6'h0F, 6'h3F, 1'b0, "lui");
    endtask

    task automatic test_mem();
        run(6'h23, 6'h00, 1'b0, "lw");
        run(6'h2B, 6'h08, 1'b1, "sw");
    endtask

    task automatic test_branch_jump();
        run(6'h04, 6'h00, 1'b1, "beq_taken");
        run(6'h04, 6'h00, 1'b0, "beq_not_taken");
        run(6'h03, 6'h00, 1'b0, "jal");
        run(6'h00, 6'h08, 1'b0, "jr");
        run(6'h02, 6'h21, 1'b1, "j");
    endtask

    task automatic test_illegal();
        run(6'h3F, 6'h00, 1'b0, "illegal_op");
        run(6'h00, 6'h20, 1'b1, "illegal_funct");
    endtask

    task automatic test_reset_mid();
        bool_reached: begin end
        bus.op    = 6'h2B;
        bus.funct = 6'h00;
        bus.zero  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #2;
            if (bus.state == 4'd7) break;
        end
        n_chk++;
        if (bus.state !== 4'd7 || bus.mem_wr !== 1'b1)
            $display("FAIL mid_reach state got %0d mem_wr %b exp 7/1", bus.state, bus.mem_wr);
        else n_pass++;
        #1 rst = 1'b0;
        #1;
        n_chk++;
        if (bus.state !== 4'd0) $display("FAIL mid_state got %0d exp 0", bus.state);
        else n_pass++;
        n_chk++;
        if (got !== ctrl_t'('0)) $display("FAIL mid_ctrl got %h exp 0", got);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (bus.state !== 4'd0 || got !== fetch_word())
            $display("FAIL mid_release state %0d ctrl %h exp 0/%h", bus.state, got, fetch_word());
        else n_pass++;
        run(6'h00, 6'h21, 1'b0, "after_reset_addu");
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops [10] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h03};
        logic [5:0] fns [3]  = '{6'h21, 6'h23, 6'h08};
        logic [5:0] o, f;
        for (int n = 0; n < 60; n++) begin
            int sel = $urandom_range(0, 12);
            f = 6'($urandom);
            if (sel < 10) o = ops[sel];
            else          o = 6'($urandom);
            if (o == 6'h00 && sel < 3) f = fns[sel];
            run(o, f, 1'($urandom), "random");
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch_jump();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        n_chk++;
        if (bus.state !== 4'd0) $display("FAIL final_state got %0d exp 0", bus.state);
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
